// File: rtl/pio_host_seq.sv
// PIO host-side sequencer: accepts one host register access, drives ATA address/CS/data,
// selects the timing set and runs one cycle on the PIO timing controller. Option: ATA_PIO_DEV_TIMING_EN.
module pio_host_seq #(
    parameter int unsigned TWIDTH = 8,
    parameter int unsigned DWIDTH = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              rst,
    input  logic              req,
    input  logic              we_i,
    input  logic [3:0]        adr_i,
    input  logic [DWIDTH-1:0] dat_i,
    output logic              ack_o,
    output logic [DWIDTH-1:0] dat_o,
    output logic              busy_o,
    input  logic [TWIDTH-1:0] Tc1,
    input  logic [TWIDTH-1:0] Tc2,
    input  logic [TWIDTH-1:0] Tc4,
    input  logic [TWIDTH-1:0] Tceoc,
    input  logic [TWIDTH-1:0] Td0_1,
    input  logic [TWIDTH-1:0] Td0_2,
    input  logic [TWIDTH-1:0] Td0_4,
    input  logic [TWIDTH-1:0] Td0_eoc,
    input  logic [TWIDTH-1:0] Td1_1,
    input  logic [TWIDTH-1:0] Td1_2,
    input  logic [TWIDTH-1:0] Td1_4,
    input  logic [TWIDTH-1:0] Td1_eoc,
    input  logic              IORDYc_en,
    input  logic              IORDYd0_en,
    input  logic              IORDYd1_en,
    output logic              go,
    output logic              we,
    output logic [TWIDTH-1:0] T1,
    output logic [TWIDTH-1:0] T2,
    output logic [TWIDTH-1:0] T4,
    output logic [TWIDTH-1:0] Teoc,
    output logic              IORDY_en,
    input  logic              done,
    input  logic              dstrb,
    output logic [2:0]        DA,
    output logic              CS0n,
    output logic              CS1n,
    output logic [DWIDTH-1:0] DDo,
    input  logic [DWIDTH-1:0] DDi
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic [1:0] {SEL_C, SEL_D0, SEL_D1} tsel_t;

    state_t            state_q;
    tsel_t             tsel_q;
    tsel_t             acc_sel;
    logic              acc_iordy;
    logic              go_q, ack_q, busy_q, we_q, iordy_q;
    logic              cs0n_q, cs1n_q;
    logic [2:0]        da_q;
    logic [DWIDTH-1:0] ddo_q, dat_q;

`ifdef ATA_PIO_DEV_TIMING_EN
    logic              dev_q;
`else
    logic              unused_d1;
    assign unused_d1 = ^{Td1_1, Td1_2, Td1_4, Td1_eoc, IORDYd1_en};
`endif

    always_comb begin
        acc_sel = SEL_C;
        if (adr_i == 4'h0) begin
`ifdef ATA_PIO_DEV_TIMING_EN
            acc_sel = dev_q ? SEL_D1 : SEL_D0;
`else
            acc_sel = SEL_D0;
`endif
        end
        case (acc_sel)
            SEL_D0:  acc_iordy = IORDYd0_en;
            SEL_D1:  acc_iordy = IORDYd1_en;
            default: acc_iordy = IORDYc_en;
        endcase
    end

    // The set selection is registered at acceptance; the reset selection (compatible)
    // makes the timing outputs track the compatible inputs without loading data in reset.
    always_comb begin
        case (tsel_q)
            SEL_D0: begin
                T1 = Td0_1; T2 = Td0_2; T4 = Td0_4; Teoc = Td0_eoc;
            end
`ifdef ATA_PIO_DEV_TIMING_EN
            SEL_D1: begin
                T1 = Td1_1; T2 = Td1_2; T4 = Td1_4; Teoc = Td1_eoc;
            end
`endif
            default: begin
                T1 = Tc1; T2 = Tc2; T4 = Tc4; Teoc = Tceoc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            tsel_q  <= SEL_C;
            go_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            iordy_q <= 1'b0;
            cs0n_q  <= 1'b1;
            cs1n_q  <= 1'b1;
            da_q    <= '0;
            ddo_q   <= '0;
            dat_q   <= '0;
`ifdef ATA_PIO_DEV_TIMING_EN
            dev_q   <= 1'b0;
`endif
        end else if (rst) begin
            state_q <= IDLE;
            tsel_q  <= SEL_C;
            go_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            iordy_q <= 1'b0;
            cs0n_q  <= 1'b1;
            cs1n_q  <= 1'b1;
            da_q    <= '0;
            ddo_q   <= '0;
            dat_q   <= '0;
`ifdef ATA_PIO_DEV_TIMING_EN
            dev_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= ISSUE;
                        go_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        we_q    <= we_i;
                        da_q    <= adr_i[2:0];
                        cs0n_q  <= adr_i[3];
                        cs1n_q  <= ~adr_i[3];
                        ddo_q   <= dat_i;
                        tsel_q  <= acc_sel;
                        iordy_q <= acc_iordy;
`ifdef ATA_PIO_DEV_TIMING_EN
                        // The Device/Head write itself already used the compatible set.
                        if (we_i && adr_i == 4'h6)
                            dev_q <= dat_i[4];
`endif
                    end
                end
                ISSUE: begin
                    go_q    <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (dstrb && !we_q)
                        dat_q <= DDi;
                    if (done) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign go       = go_q;
    assign ack_o    = ack_q;
    assign busy_o   = busy_q;
    assign we       = we_q;
    assign IORDY_en = iordy_q;
    assign DA       = da_q;
    assign CS0n     = cs0n_q;
    assign CS1n     = cs1n_q;
    assign DDo      = ddo_q;
    assign dat_o    = dat_q;

endmodule
